// File: rtl/oam_dma.sv
// Sprite DMA engine: a $4014 write halts the CPU and copies one 256-byte
// page to OAMDATA ($2004) as aligned read/write pairs.
module oam_dma (
   input  logic        i_cpu_clk,
   input  logic        i_cpu_rstn,
   input  logic [15:0] i_bus_addr,
   input  logic        i_bus_wn,
   input  logic [7:0]  i_bus_wdata,
   output logic        o_cpu_rdy,
   output logic        o_dma_busy,
   output logic [15:0] o_dma_addr,
   output logic        o_dma_wn,
   output logic [7:0]  o_dma_wdata,
   input  logic [7:0]  i_dma_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_e;

   state_e     state_q, state_d;
   logic       par_q, par_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] data_q, data_d;
   logic       trig;

   assign trig = (i_bus_addr == 16'h4014) && !i_bus_wn;

   always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
      if (!i_cpu_rstn) begin
         state_q <= S_IDLE;
         par_q   <= 1'b0;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         par_q   <= par_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      par_d   = ~par_q;
      page_d  = page_q;
      idx_d   = idx_q;
      data_d  = data_q;
      unique case (state_q)
         S_IDLE: begin
            if (trig) begin
               page_d  = i_bus_wdata;
               idx_d   = 8'h00;
               state_d = S_HALT;
            end
         end
         // odd parity now means the following cycle is even
         S_HALT:  state_d = par_q ? S_READ : S_ALIGN;
         S_ALIGN: state_d = S_READ;
         S_READ: begin
            data_d  = i_dma_rdata;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            idx_d   = idx_q + 8'h01;
            state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_dma_busy  = (state_q != S_IDLE);
      o_cpu_rdy   = ~o_dma_busy;
      o_dma_addr  = 16'h0000;
      o_dma_wn    = 1'b1;
      o_dma_wdata = data_q;
      unique case (state_q)
         S_READ:  o_dma_addr = {page_q, idx_q};
         S_WRITE: begin
            o_dma_addr = 16'h2004;
            o_dma_wn   = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: idle-bus vector table plus full-transfer,
// alignment, page-$FF, busy-retrigger and mid-transfer reset sequences.
module tb_oam_dma;

   logic        clk;
   logic        rst_n;
   logic [15:0] bus_addr;
   logic        bus_wn;
   logic [7:0]  bus_wdata;
   logic        cpu_rdy;
   logic        dma_busy;
   logic [15:0] dma_addr;
   logic        dma_wn;
   logic [7:0]  dma_wdata;
   logic [7:0]  dma_rdata;

   int checks = 0;
   int errors = 0;
   logic tb_par;

   oam_dma dut (
      .i_cpu_clk  (clk),
      .i_cpu_rstn (rst_n),
      .i_bus_addr (bus_addr),
      .i_bus_wn   (bus_wn),
      .i_bus_wdata(bus_wdata),
      .o_cpu_rdy  (cpu_rdy),
      .o_dma_busy (dma_busy),
      .o_dma_addr (dma_addr),
      .o_dma_wn   (dma_wn),
      .o_dma_wdata(dma_wdata),
      .i_dma_rdata(dma_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory image: byte at $XX00+i is i^$5A
   assign dma_rdata = dma_addr[7:0] ^ 8'h5A;

   // reference cycle parity
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_par <= 1'b0;
      else        tb_par <= ~tb_par;
   end

   typedef struct {
      logic [15:0] addr;
      logic        wn;
      logic [7:0]  wdata;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      bus_addr  = 16'h0000;
      bus_wn    = 1'b1;
      bus_wdata = 8'h00;
   endtask

   // Trigger a transfer and follow it cycle by cycle.
   task automatic run_xfer(input logic [7:0] page, input logic align,
                           input int inject_at);
      int   k;
      int   base;
      int   rel;
      int   j;
      int   bad;
      logic saw_zero;
      logic [15:0] ea;
      logic        ew;
      logic [7:0]  ed;
      // a trigger in an even cycle puts T+2 on an even cycle
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (tb_par !== align && k < 4);
      bus_addr  = 16'h4014;
      bus_wn    = 1'b0;
      bus_wdata = page;
      @(posedge clk);
      #1 bus_idle();
      base     = align ? 2 : 1;
      bad      = 0;
      saw_zero = 1'b0;
      k        = 0;
      while (k < 600) begin
         @(negedge clk);
         if (dma_busy !== 1'b1) break;
         if (inject_at >= 0) bus_idle();
         if (dma_addr == 16'h0000 && k >= base) saw_zero = 1'b1;
         ed = dma_wdata;
         if (k < base) begin
            ea = 16'h0000;
            ew = 1'b1;
         end else begin
            rel = k - base;
            j   = rel / 2;
            if (rel % 2 == 0) begin
               ea = {page, j[7:0]};
               ew = 1'b1;
               if (tb_par !== 1'b0) bad++;
            end else begin
               ea = 16'h2004;
               ew = 1'b0;
               ed = j[7:0] ^ 8'h5A;
            end
         end
         if (dma_addr !== ea || dma_wn !== ew || dma_wdata !== ed ||
             cpu_rdy !== 1'b0) begin
            if (bad < 4)
               $display("FAIL xfer p%0h k%0d: addr %0h wn %0b d %0h rdy %0b, expected addr %0h wn %0b d %0h rdy 0",
                        page, k, dma_addr, dma_wn, dma_wdata, cpu_rdy,
                        ea, ew, ed);
            bad++;
         end
         if (k == inject_at) begin
            bus_addr  = 16'h4014;
            bus_wn    = 1'b0;
            bus_wdata = 8'h07;
         end
         k++;
      end
      bus_idle();
      check($sformatf("xfer_seq_p%0h", page), bad, 0);
      check($sformatf("busy_len_p%0h", page), k, align ? 514 : 513);
      check($sformatf("rdy_after_p%0h", page), {cpu_rdy, dma_wn}, 2'b11);
      if (page == 8'hFF) check("no_read_0000", saw_zero, 0);
   endtask

   initial begin
      int k;
      int bad;
      bus_idle();
      rst_n = 1'b0;
      #22;
      check("rst_rdy_busy", {cpu_rdy, dma_busy}, 2'b10);
      check("rst_addr", dma_addr, 16'h0000);
      check("rst_wn_wdata", {dma_wn, dma_wdata}, 9'h100);
      @(negedge clk);
      rst_n = 1'b1;

      vecs[0] = '{16'h4014, 1'b1, 8'h02, 1'b0};
      vecs[1] = '{16'h4015, 1'b0, 8'h02, 1'b0};
      vecs[2] = '{16'h4013, 1'b0, 8'h02, 1'b0};
      vecs[3] = '{16'h0014, 1'b0, 8'h02, 1'b0};
      vecs[4] = '{16'hC014, 1'b0, 8'h02, 1'b0};
      vecs[5] = '{16'h2004, 1'b0, 8'h02, 1'b0};
      foreach (vecs[i]) begin
         @(negedge clk);
         bus_addr  = vecs[i].addr;
         bus_wn    = vecs[i].wn;
         bus_wdata = vecs[i].wdata;
         @(negedge clk);
         bus_idle();
         check($sformatf("vec%0d_busy_rdy", i), {dma_busy, cpu_rdy},
               {vecs[i].exp_busy, ~vecs[i].exp_busy});
         @(negedge clk);
         check($sformatf("vec%0d_bus_rest", i), {dma_addr, dma_wn},
               {16'h0000, 1'b1});
      end

      run_xfer(8'h02, 1'b0, -1);
      run_xfer(8'h02, 1'b1, -1);
      run_xfer(8'hFF, 1'b0, -1);
      run_xfer(8'h03, 1'b0, 100);

      // reset during the write of index 40 (k = 1 + 2*40 + 1)
      @(negedge clk);
      while (tb_par !== 1'b0) @(negedge clk);
      bus_addr  = 16'h4014;
      bus_wn    = 1'b0;
      bus_wdata = 8'h04;
      @(posedge clk);
      #1 bus_idle();
      for (int i = 0; i <= 82; i++) @(negedge clk);
      check("pre_rst_write40", {dma_addr, dma_wn, dma_wdata},
            {16'h2004, 1'b0, 8'd40 ^ 8'h5A});
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_busy_rdy", {dma_busy, cpu_rdy}, 2'b01);
      check("async_rst_addr_wn", {dma_addr, dma_wn}, {16'h0000, 1'b1});
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (dma_busy !== 1'b0 || dma_wn !== 1'b1 ||
             dma_addr !== 16'h0000) bad++;
      end
      check("no_resume_after_rst", bad, 0);
      run_xfer(8'h05, 1'b1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
